// File: rtl/ysyx_25040129_ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one read per instruction,
// and hands each returned word with its PC to decode over valid/ready.
module ysyx_25040129_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        is_req_valid_to_idu,
  input  logic        is_req_ready_from_idu,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inst_q;
  logic [31:0] r_pc_q;
  logic        r_pend;
  logic [31:0] r_pend_pc;
  logic        r_fetch_err;

  state_t      w_state_n;
  logic [31:0] w_fetch_pc_n;
  logic [31:0] w_inst_q_n;
  logic [31:0] w_pc_q_n;
  logic        w_pend_n;
  logic [31:0] w_pend_pc_n;
  logic        w_fetch_err_n;
  logic [31:0] w_redirect_pc;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // Next-state logic. A redirect seen while a read is in flight is parked in
  // pend/pend_pc so the outstanding read can still complete on the bus.
  always_comb begin
    w_state_n     = r_state;
    w_fetch_pc_n  = r_fetch_pc;
    w_inst_q_n    = r_inst_q;
    w_pc_q_n      = r_pc_q;
    w_pend_n      = r_pend;
    w_pend_pc_n   = r_pend_pc;
    w_fetch_err_n = r_fetch_err;

    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pend_n    = 1'b1;
          w_pend_pc_n = w_redirect_pc;
        end
        if (arready) begin
          w_state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        if (rvalid) begin
          if (r_pend || redirect_valid) begin
            w_fetch_pc_n = redirect_valid ? w_redirect_pc : r_pend_pc;
            w_pend_n     = 1'b0;
            w_state_n    = S_REQ;
          end else if (rresp != 2'b00) begin
            w_fetch_err_n = 1'b1;
            w_state_n     = S_ERR;
          end else begin
            w_inst_q_n = rdata;
            w_pc_q_n   = r_fetch_pc;
            w_state_n  = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_pend_n    = 1'b1;
          w_pend_pc_n = w_redirect_pc;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_fetch_pc_n = w_redirect_pc;
          w_state_n    = S_REQ;
        end else if (is_req_ready_from_idu) begin
          w_fetch_pc_n = r_fetch_pc + 32'd4;
          w_state_n    = S_REQ;
        end
      end

      S_ERR: begin
        w_state_n = S_ERR;
      end

      default: begin
        w_state_n = S_REQ;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_fetch_pc  <= RESET_PC;
      r_inst_q    <= NOP_INST;
      r_pc_q      <= 32'h0000_0000;
      r_pend      <= 1'b0;
      r_pend_pc   <= 32'h0000_0000;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_fetch_pc  <= w_fetch_pc_n;
      r_inst_q    <= w_inst_q_n;
      r_pc_q      <= w_pc_q_n;
      r_pend      <= w_pend_n;
      r_pend_pc   <= w_pend_pc_n;
      r_fetch_err <= w_fetch_err_n;
    end
  end

  // A redirect in HOLD kills the handshake in the same cycle.
  assign arvalid             = (r_state == S_REQ);
  assign rready              = (r_state == S_WAIT);
  assign is_req_valid_to_idu = (r_state == S_HOLD) && !redirect_valid;
  assign araddr              = r_fetch_pc;
  assign inst                = r_inst_q;
  assign pc                  = r_pc_q;
  assign fetch_err           = r_fetch_err;

endmodule

// File: tb/tb_ysyx_25040129_ifu_fetch.sv
// Bench for the fetch stage: directed vector table, hand sequences for redirect
// corners, and a randomized run against a transaction-level program-order model.
module tb_ysyx_25040129_ifu_fetch;

  localparam logic [31:0] A0  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic        ready;
  logic        redir;
  logic [31:0] redirPc;
  logic        fetchErr;

  int checkCount = 0;
  int errorCount = 0;

  ysyx_25040129_ifu_fetch dut (
    .clk                   (clk),
    .rst                   (rst),
    .araddr                (araddr),
    .arvalid               (arvalid),
    .arready               (arready),
    .rdata                 (rdata),
    .rresp                 (rresp),
    .rvalid                (rvalid),
    .rready                (rready),
    .inst                  (inst),
    .pc                    (pc),
    .is_req_valid_to_idu   (valid),
    .is_req_ready_from_idu (ready),
    .redirect_valid        (redir),
    .redirect_pc           (redirPc),
    .fetch_err             (fetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        ready;
    logic        redir;
    logic [31:0] redirPc;
    logic        chk;
    logic        expArvalid;
    logic [31:0] expAraddr;
    logic        expRready;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInst;
    logic        expErr;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic vec_t mk(input logic iRst, input logic iAr, input logic iRv,
                              input logic [31:0] iRdata, input logic [1:0] iRresp,
                              input logic iRdy, input logic iRedir, input logic [31:0] iRpc,
                              input logic iChk, input logic eArv, input logic [31:0] eAraddr,
                              input logic eRr, input logic eV, input logic [31:0] ePc,
                              input logic [31:0] eInst, input logic eErr);
    vec_t v;
    v.rst = iRst; v.arready = iAr; v.rvalid = iRv; v.rdata = iRdata; v.rresp = iRresp;
    v.ready = iRdy; v.redir = iRedir; v.redirPc = iRpc; v.chk = iChk;
    v.expArvalid = eArv; v.expAraddr = eAraddr; v.expRready = eRr; v.expValid = eV;
    v.expPc = ePc; v.expInst = eInst; v.expErr = eErr;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic iRst, input logic iAr, input logic iRv,
                               input logic [31:0] iRdata, input logic [1:0] iRresp,
                               input logic iRdy, input logic iRedir, input logic [31:0] iRpc);
    @(negedge clk);
    rst = iRst; arready = iAr; rvalid = iRv; rdata = iRdata; rresp = iRresp;
    ready = iRdy; redir = iRedir; redirPc = iRpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eArv, input logic [31:0] eAraddr,
                          input logic eRr, input logic eV, input logic [31:0] ePc,
                          input logic [31:0] eInst, input logic eErr);
    checkOutput({tag, ".arvalid"}, {31'd0, arvalid}, {31'd0, eArv});
    checkOutput({tag, ".araddr"}, araddr, eAraddr);
    checkOutput({tag, ".rready"}, {31'd0, rready}, {31'd0, eRr});
    checkOutput({tag, ".valid"}, {31'd0, valid}, {31'd0, eV});
    checkOutput({tag, ".pc"}, pc, ePc);
    checkOutput({tag, ".inst"}, inst, eInst);
    checkOutput({tag, ".fetch_err"}, {31'd0, fetchErr}, {31'd0, eErr});
  endtask

  task automatic resetDut();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Transaction-level random run: every delivered (pc, inst) must follow
  // program order (+4) unless a redirect happened since the last delivery.
  task automatic randomRun(input int cycles);
    logic [31:0] expPc;
    logic        memBusy;
    logic [31:0] memAddr;
    int          memDelay;
    logic        prevPending;
    logic [31:0] prevAddr;
    int          delivered;
    int          idle;
    logic        stuck;
    logic        arV, rvV, rdyV, redV;
    logic [31:0] rpcV;

    resetDut();
    expPc = A0; memBusy = 1'b0; memAddr = 32'h0; memDelay = 0;
    prevPending = 1'b0; prevAddr = 32'h0; delivered = 0; idle = 0; stuck = 1'b0;

    for (int cyc = 0; cyc < cycles && !stuck; cyc++) begin
      arV  = !memBusy && ($urandom_range(0, 3) != 0);
      rvV  = memBusy && (memDelay == 0);
      rdyV = ($urandom_range(0, 1) == 1);
      redV = ($urandom_range(0, 9) == 0);
      rpcV = $urandom;
      applyStimulus(0, arV, rvV, rvV ? memWord(memAddr) : 32'h0, 2'b00, rdyV, redV, rpcV);

      if (prevPending) begin
        checkOutput("rand.arvalid_held", {31'd0, arvalid}, 32'd1);
        checkOutput("rand.araddr_stable", araddr, prevAddr);
      end
      if (rvV) checkOutput("rand.rready", {31'd0, rready}, 32'd1);
      if (redV) checkOutput("rand.valid_killed", {31'd0, valid}, 32'd0);

      if (valid && rdyV) begin
        checkOutput("rand.pc", pc, expPc);
        checkOutput("rand.inst", inst, memWord(pc));
        expPc = pc + 32'd4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      if (redV) expPc = rpcV & 32'hFFFF_FFFC;

      if (rvV && rready) memBusy = 1'b0;
      else if (memBusy && memDelay > 0) memDelay--;
      if (arvalid && arV) begin
        memBusy = 1'b1;
        memAddr = araddr;
        memDelay = $urandom_range(0, 3);
      end
      prevPending = arvalid && !arV;
      prevAddr = araddr;

      if (idle > 200) begin
        checkOutput("rand.liveness_idle", idle, 0);
        stuck = 1'b1;
      end
    end
    checkOutput("rand.enough_delivered", {31'd0, (delivered >= 100)}, 32'd1);
  endtask

  initial begin
    logic [31:0] a4, a8, w0, w1, w2;
    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    ready = 1'b0; redir = 1'b0; redirPc = 32'h0;

    a4 = A0 + 32'd4; a8 = A0 + 32'd8;
    w0 = memWord(A0); w1 = memWord(a4); w2 = memWord(a8);

    vecs[0]  = mk(1,0,0,0,0,0,0,0,                 0, 0,0,0,0,0,0,0);
    vecs[1]  = mk(1,0,0,0,0,0,0,0,                 1, 1,A0,0,0,0,NOP,0);
    vecs[2]  = mk(0,1,0,0,0,0,0,0,                 1, 1,A0,0,0,0,NOP,0);
    vecs[3]  = mk(0,0,1,w0,0,0,0,0,                1, 0,A0,1,0,0,NOP,0);
    vecs[4]  = mk(0,0,0,0,0,1,0,0,                 1, 0,A0,0,1,A0,w0,0);
    vecs[5]  = mk(0,1,0,0,0,0,0,0,                 1, 1,a4,0,0,A0,w0,0);
    vecs[6]  = mk(0,0,1,w1,0,0,0,0,                1, 0,a4,1,0,A0,w0,0);
    for (int i = 7; i <= 11; i++)
      vecs[i] = mk(0,0,0,0,0,0,0,0,                1, 0,a4,0,1,a4,w1,0);
    vecs[12] = mk(0,0,0,0,0,1,0,0,                 1, 0,a4,0,1,a4,w1,0);
    vecs[13] = mk(0,1,0,0,0,0,0,0,                 1, 1,a8,0,0,a4,w1,0);
    vecs[14] = mk(0,0,1,w2,0,0,0,0,                1, 0,a8,1,0,a4,w1,0);
    vecs[15] = mk(0,0,0,0,0,1,1,32'h8000_0403,     1, 0,a8,0,0,a8,w2,0);
    vecs[16] = mk(0,0,0,0,0,0,0,0,                 1, 1,32'h8000_0400,0,0,a8,w2,0);
    vecs[17] = mk(0,1,0,0,0,0,0,0,                 1, 1,32'h8000_0400,0,0,a8,w2,0);
    vecs[18] = mk(0,0,1,32'hDEAD_BEEF,2'b10,0,0,0, 1, 0,32'h8000_0400,1,0,a8,w2,0);
    vecs[19] = mk(0,1,0,0,0,1,0,0,                 1, 0,32'h8000_0400,0,0,a8,w2,1);
    vecs[20] = mk(0,1,0,0,0,1,1,32'h8000_0700,     1, 0,32'h8000_0400,0,0,a8,w2,1);
    vecs[21] = mk(1,0,0,0,0,0,0,0,                 1, 0,32'h8000_0400,0,0,a8,w2,1);
    vecs[22] = mk(0,0,0,0,0,0,0,0,                 1, 1,A0,0,0,0,NOP,0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].arready, vecs[i].rvalid, vecs[i].rdata,
                    vecs[i].rresp, vecs[i].ready, vecs[i].redir, vecs[i].redirPc);
      if (vecs[i].chk)
        checkAll($sformatf("vec%0d", i), vecs[i].expArvalid, vecs[i].expAraddr,
                 vecs[i].expRready, vecs[i].expValid, vecs[i].expPc,
                 vecs[i].expInst, vecs[i].expErr);
    end

    // Redirect while waiting; data arrives three cycles later and is dropped.
    resetDut();
    applyStimulus(0,1,0,0,0,0,0,0);            checkAll("A.req",1,A0,0,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,0,1,32'h8000_0100); checkAll("A.wait_redir",0,A0,1,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0);
    applyStimulus(0,0,1,32'hCAFE_0001,0,1,0,0); checkAll("A.rvalid",0,A0,1,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,1,0,0);            checkAll("A.refetch",1,32'h8000_0100,0,0,0,NOP,0);
    applyStimulus(0,1,0,0,0,0,0,0);
    applyStimulus(0,0,1,memWord(32'h8000_0100),0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0);
    checkAll("A.hold",0,32'h8000_0100,0,1,32'h8000_0100,memWord(32'h8000_0100),0);

    // Redirect in REQ with arready low, then a newer redirect before rvalid.
    resetDut();
    applyStimulus(0,0,0,0,0,0,1,32'h8000_0200); checkAll("B.req_redir",1,A0,0,0,0,NOP,0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0,0,0,0,0,0);          checkAll($sformatf("B.req_stall%0d", i),1,A0,0,0,0,NOP,0);
    end
    applyStimulus(0,1,0,0,0,0,0,0);            checkAll("B.req_acc",1,A0,0,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,0,1,32'h8000_0300); checkAll("B.wait_redir2",0,A0,1,0,0,NOP,0);
    applyStimulus(0,0,1,memWord(A0),0,1,0,0);  checkAll("B.discard",0,A0,1,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,0,0,0);            checkAll("B.refetch",1,32'h8000_0300,0,0,0,NOP,0);
    applyStimulus(0,1,0,0,0,0,0,0);
    applyStimulus(0,0,1,memWord(32'h8000_0300),0,1,1,32'h8000_0502);
    checkAll("B.sim_wait",0,32'h8000_0300,1,0,0,NOP,0);
    applyStimulus(0,0,0,0,0,0,0,0);            checkAll("B.sim_refetch",1,32'h8000_0500,0,0,0,NOP,0);

    // Reset mid-read, then a redirect to the top word and wrap of pc+4.
    resetDut();
    applyStimulus(0,1,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0);
    applyStimulus(1,0,0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,0,0,0);            checkAll("C.after_rst",1,A0,0,0,0,NOP,0);
    applyStimulus(0,1,0,0,0,0,0,0);
    applyStimulus(0,0,1,memWord(A0),0,0,0,0);
    applyStimulus(0,0,0,0,0,1,1,32'hFFFF_FFFF); checkAll("C.hold_redir",0,A0,0,0,A0,memWord(A0),0);
    applyStimulus(0,0,0,0,0,0,0,0);            checkAll("C.wrap_req",1,32'hFFFF_FFFC,0,0,A0,memWord(A0),0);
    applyStimulus(0,1,0,0,0,0,0,0);
    applyStimulus(0,0,1,memWord(32'hFFFF_FFFC),0,0,0,0);
    applyStimulus(0,0,0,0,0,1,0,0);
    checkAll("C.wrap_hold",0,32'hFFFF_FFFC,0,1,32'hFFFF_FFFC,memWord(32'hFFFF_FFFC),0);
    applyStimulus(0,0,0,0,0,0,0,0);
    checkAll("C.wrap_next",1,32'h0000_0000,0,0,32'hFFFF_FFFC,memWord(32'hFFFF_FFFC),0);

    randomRun(4000);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_ifu_fetch.md
# ysyx_25040129_ifu_fetch

Instruction-fetch stage directly upstream of the decode stage. Owns the architectural fetch PC, issues one AXI4-Lite-style read per instruction to instruction memory, and presents the returned word with its PC to decode over a valid/ready handshake. Accepts redirects from execute (branch, jump, ecall, mret, fence.i refetch) and discards wrong-path fetches without breaking bus protocol.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; **synchronous, active-high**.
- araddr  out  32  fetch address; equals fetch_pc while arvalid.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts address.
- rdata  in  32  returned instruction word.
- rresp  in  2  response code; 2'b00 = OKAY, anything else = fault.
- rvalid  in  1  read data valid.
- rready  out  1  fetch stage accepts data.
- inst  out  32  instruction to decode.
- pc  out  32  PC of inst.
- is_req_valid_to_idu  out  1  inst/pc valid.
- is_req_ready_from_idu  in  1  decode accepts (already includes its hazard stall).
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 2'b00.
- fetch_err  out  1  sticky instruction-access fault.

## Operation
- States (2-bit): REQ, WAIT, HOLD, ERR.
- Registers: fetch_pc, inst_q, pc_q, pend (redirect pending), pend_pc, fetch_err.
- Outputs:
  - arvalid = (state==REQ).
  - rready = (state==WAIT).
  - is_req_valid_to_idu = (state==HOLD) && !redirect_valid.
  - inst = inst_q; pc = pc_q; araddr = fetch_pc.
- REQ:
  - redirect_valid && !arready: pend←1, pend_pc←redirect_pc; stay in REQ. araddr must not change while arvalid is asserted.
  - arready: →WAIT. If redirect_valid in the same cycle, also set pend/pend_pc.
- WAIT:
  - A redirect_valid while waiting sets pend/pend_pc. The latest redirect always overwrites pend_pc.
  - On rvalid, if pend || redirect_valid: discard the data; fetch_pc←(redirect_valid ? redirect_pc : pend_pc); pend←0; →REQ. Discarded faults are ignored.
  - On rvalid with rresp≠0 and not discarding: fetch_err←1; →ERR.
  - On rvalid otherwise: inst_q←rdata; pc_q←fetch_pc; →HOLD.
- HOLD:
  - redirect_valid has priority: fetch_pc←redirect_pc, →REQ, no handshake to decode.
  - Else if is_req_ready_from_idu: fetch_pc←fetch_pc+4, →REQ.
  - Else hold; inst/pc stable.
- ERR: terminal. All handshake outputs are 0; only rst leaves ERR.
- Arithmetic: fetch_pc+4 is modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values (after the rst edge): state=REQ, fetch_pc=RESET_PC, inst_q=32'h0000_0013 (nop), pc_q=0, pend=0, fetch_err=0.
  - arvalid=1 in the first cycle with rst low.
  - is_req_valid_to_idu=0, rready=0.
- rst asserted mid-transaction: all state is reset at the next edge.
  - An outstanding read is abandoned. Memory is reset by the same rst.
- Minimum latency with arready=1 and rvalid one cycle later:
  - REQ at cycle n, WAIT at n+1, HOLD at n+2.
  - Next REQ at n+3 if decode is ready.
  - Throughput: one instruction per 3 cycles.
- Decode handshake completes in the cycle where valid&&ready is high.
  - inst/pc stay stable from HOLD entry until then.
- A redirect in the same cycle as a HOLD handshake: redirect wins, and valid is forced low that cycle.
- Simultaneous rvalid and redirect_valid in WAIT: the data is discarded and redirect_pc is used.

## Test plan
- Reset with RESET_PC=32'h8000_0000, zero-wait memory → araddr 8000_0000, 8000_0004, 8000_0008. Each inst delivered with matching pc; valid never high during rst.
- Decode stalls 5 cycles in HOLD (ready=0) → inst/pc constant, valid high throughout. fetch_pc advances only after ready.
- redirect_valid (pc 8000_0100) while in WAIT with rvalid 3 cycles later → returned word not presented. Next araddr=8000_0100.
- Redirect to 8000_0200 during REQ with arready held low 4 cycles → araddr stays at old value until the handshake. Data is discarded; next araddr=8000_0200. A second redirect to 8000_0300 before rvalid → next araddr=8000_0300.
- Redirect and ready in the same HOLD cycle → valid low that cycle. Next araddr=redirect_pc; redirect_pc=8000_0403 gives araddr 8000_0400.
- rresp=2'b10 on a fetch → fetch_err=1 and ERR held, arvalid=0. rst clears fetch_err; fetch restarts at RESET_PC.
